fixed_argmax_stream: RTL and testbench
======================================

Name: fixed_argmax_stream

Overview:
- Streaming max/argmax reducer for sign-magnitude fixed-point activations in the Q-format datapath (1 sign bit, N-1 magnitude bits, Q fractional bits).
- Consumes a frame of values over a valid/ready stream and returns the largest value, its position in the frame, and the frame length.
- Sits at the classifier output; it replaces ad hoc pairwise selection trees with a correct, sequential, one-compare-per-cycle reduction.

Parameters:
- Q, 16, fractional bits (informational only; comparison is format-agnostic).
- N, 32, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude.
- MAX_LEN, 1024, maximum elements per frame; IDX_W = $clog2(MAX_LEN), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  N  sign-magnitude input value.
- in_last  in  1  this beat ends the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_max  out  N  maximum value in the frame, exactly as received.
- out_index  out  IDX_W  0-based index of the first occurrence of the maximum.
- out_count  out  IDX_W+1  number of beats in the frame, saturating at MAX_LEN.
- out_ovf  out  1  frame exceeded MAX_LEN beats.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=ACCUM; in_ready=1; out_valid=0; out_max, out_index, out_count, out_ovf all 0. The internal first-beat flag is set to 1.
- Input accept: a beat is accepted when in_valid && in_ready. in_ready is a pure decode of state: 1 in ACCUM, 0 in HOLD.
- States:
  - ACCUM: on an accept with first=1, load best=in_data, bidx=0, cnt=1, and clear first.
  - ACCUM: on an accept with first=0, update best and bidx to in_data and the current position only if in_data is strictly greater than best. cnt increments.
  - ACCUM to HOLD: on an accept with in_last=1. The last beat's compare happens in the same cycle.
  - HOLD: out_valid=1 and the outputs are registered and stable. On out_valid && out_ready, go to ACCUM, set first=1, and clear out_valid on the next edge.
  - The one-cycle bubble before in_ready rises again is required.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, i.e. outputs are visible the cycle after that beat.
- Value ordering:
  - A sign-magnitude value is negative iff sign=1 and magnitude != 0.
  - +0 and -0 compare equal.
  - Any non-negative value is greater than any negative value.
  - Between two negatives, the smaller magnitude is greater.
  - Between two non-negatives, the larger magnitude is greater.
- Ties: the earliest index is kept, because a replacement requires strict greater-than. out_max returns the stored word bit-exact, so -0 stays -0 when it is the first maximum.
- Position counter:
  - The position of a beat is cnt before its increment.
  - cnt saturates at MAX_LEN.
  - A beat arriving when cnt=MAX_LEN sets out_ovf=1 (sticky for the frame) and does not update best or bidx.
  - The frame still ends only on in_last.
- Single-beat frame (first beat has in_last=1): out_max=in_data, out_index=0, out_count=1.
- in_last when the frame is otherwise empty is not a special case; every frame has at least one beat.
- Backpressure: while out_ready=0, HOLD persists indefinitely with outputs stable and in_ready=0.
- Reset mid-frame or during HOLD: the partial frame and the pending result are discarded, and all registers return to their reset values.

Decomposition:
- Shared package fxp_pkg: the N and Q defaults, and a sign-magnitude "is negative" helper function, reused by other datapath blocks.
- Sub-module sm_gt: combinational, parameter N, inputs a and b, output a_gt_b, implementing the strict ordering above. It is instantiated once, and it becomes the team's canonical sign-magnitude comparator.

Test Plan (Q=16, N=32):
- Frame {0x00018000 (+1.5), 0x80020000 (-2.0), 0x00030000 (+3.0), 0x00010000} with in_last on beat 4 -> out_max=0x00030000, out_index=2, out_count=4, out_ovf=0, out_valid one cycle after the last accept.
- All-negative frame {0x80030000, 0x80008000, 0x80010000} -> out_max=0x80008000 (-0.5), out_index=1.
- Ties and zeros {0x80000000 (-0), 0x00000000 (+0), 0x80000000} -> out_max=0x80000000, out_index=0. Then {0x00020000, 0x00020000} -> out_index=0.
- Single-beat frame 0x80050000 with in_last -> out_max=0x80050000, out_index=0, out_count=1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; handshake -> in_ready=1 on the following cycle.
- MAX_LEN=4, frame of 6 beats with the maximum 0x00090000 on beat 5 -> out_count=4, out_ovf=1, and out_max/out_index reflect only beats 0-3.
- Assert rst_n=0 asynchronously mid-frame and again during HOLD -> out_valid=0 immediately. A following frame {0x00010000} -> out_index=0, out_count=1, with no carry-over from the discarded frame.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared sign-magnitude fixed-point definitions for the datapath blocks.
package fxp_pkg;

  localparam int FXP_N = 32;
  localparam int FXP_Q = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } argmax_state_e;

  // Negative only with a nonzero magnitude, so -0 behaves like +0.
  function automatic logic sm_is_neg(input logic sign, input logic mag_nz);
    return sign & mag_nz;
  endfunction

endpackage

// File: rtl/fixed_argmax_stream_if.sv
// Input beat stream plus result handshake for the argmax reducer.
interface fixed_argmax_stream_if
  import fxp_pkg::*;
#(
  parameter int N     = FXP_N,
  parameter int IDX_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_max;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_index, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_index, out_count, out_ovf
  );
endinterface

// File: rtl/sm_gt.sv
// Strict greater-than for sign-magnitude words; +0 and -0 compare equal.
module sm_gt
  import fxp_pkg::*;
#(
  parameter int N = FXP_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         a_gt_b
);
  logic [N-2:0] a_mag, b_mag;
  logic         a_neg, b_neg;

  assign a_mag = a[N-2:0];
  assign b_mag = b[N-2:0];
  assign a_neg = sm_is_neg(a[N-1], |a_mag);
  assign b_neg = sm_is_neg(b[N-1], |b_mag);

  always_comb begin
    if (a_neg != b_neg) a_gt_b = b_neg;
    else if (a_neg)     a_gt_b = (a_mag < b_mag);
    else                a_gt_b = (a_mag > b_mag);
  end
endmodule

// File: rtl/fixed_argmax_stream.sv
// Sequential max/argmax over a framed sign-magnitude stream, one compare per beat.
module fixed_argmax_stream
  import fxp_pkg::*;
#(
  parameter  int Q       = FXP_Q,
  parameter  int N       = FXP_N,
  parameter  int MAX_LEN = 1024,
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input logic clk,
  input logic rst_n,
  fixed_argmax_stream_if.slave bus
);
  localparam int             CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("fixed_argmax_stream: Q must lie within the magnitude field");
  end

  argmax_state_e    state_q, state_d;
  logic             first_q, first_d;
  logic [N-1:0]     best_q, best_d;
  logic [IDX_W-1:0] bidx_q, bidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic in_ready, accept, in_gt_best;

  assign in_ready = (state_q == ST_ACCUM);
  assign accept   = bus.in_valid && in_ready;

  sm_gt #(.N(N)) u_gt (
    .a      (bus.in_data),
    .b      (best_q),
    .a_gt_b (in_gt_best)
  );

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    best_d      = best_q;
    bidx_d      = bidx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (first_q) begin
            best_d  = bus.in_data;
            bidx_d  = '0;
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            first_d = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            // Beats past the frame limit are counted as overflow only.
            ovf_d = 1'b1;
          end else begin
            if (in_gt_best) begin
              best_d = bus.in_data;
              bidx_d = cnt_q[IDX_W-1:0];
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bus.in_last) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d     = ST_ACCUM;
          first_d     = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      first_q     <= 1'b1;
      best_q      <= '0;
      bidx_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      best_q      <= best_d;
      bidx_q      <= bidx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = best_q;
  assign bus.out_index = bidx_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_fixed_argmax_stream.sv
// Directed bench: two reducers (MAX_LEN 1024 and 4) fed the same stream.
module tb_fixed_argmax_stream;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fixed_argmax_stream_if #(.N(N), .IDX_W(10)) bus ();
  fixed_argmax_stream_if #(.N(N), .IDX_W(2))  bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.in_last   = bus.in_last;
  assign bus4.out_ready = bus.out_ready;

  fixed_argmax_stream #(.Q(16), .N(N), .MAX_LEN(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  fixed_argmax_stream #(.Q(16), .N(N), .MAX_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    int          start;
    int          len;
    logic [31:0] mx;
    int          ix;
    int          cn;
    logic        ov;
    logic [31:0] mx4;
    int          ix4;
    int          cn4;
    logic        ov4;
  } vec_t;

  localparam int NB = 27;
  localparam int NV = 9;
  logic [31:0] beats [NB];
  vec_t        tbl   [NV];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Starts and ends on a negedge; in_valid stays high for the caller to clear.
  task automatic drive_beat(input logic [31:0] d, input logic last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!(bus.in_ready && bus4.in_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("ready_timeout", 64'd0, 64'd1);
    if (last) chk("pre_last_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hs_valid",   64'(bus.out_valid),  64'd0);
    chk("hs_valid4",  64'(bus4.out_valid), 64'd0);
    chk("hs_ready",   64'(bus.in_ready),   64'd1);
    chk("hs_ready4",  64'(bus4.in_ready),  64'd1);
  endtask

  initial begin
    beats = '{
      32'h00018000, 32'h80020000, 32'h00030000, 32'h00010000,            // 0
      32'h80030000, 32'h80008000, 32'h80010000,                          // 4
      32'h00010000, 32'h80010000, 32'h00020000, 32'h00005000,
      32'h00090000, 32'h00030000,                                        // 7
      32'h80000000, 32'h00000000, 32'h80000000,                          // 13
      32'h00020000, 32'h00020000,                                        // 16
      32'hFFFFFFFF, 32'h80000001, 32'h80000000,                          // 18
      32'h00000000, 32'h7FFFFFFF, 32'h80000000,                          // 21
      32'h80000000, 32'h80000005,                                        // 24
      32'h80050000                                                       // 26
    };
    tbl[0] = '{0,  4, 32'h00030000, 2, 4, 1'b0, 32'h00030000, 2, 4, 1'b0};
    tbl[1] = '{4,  3, 32'h80008000, 1, 3, 1'b0, 32'h80008000, 1, 3, 1'b0};
    tbl[2] = '{7,  6, 32'h00090000, 4, 6, 1'b0, 32'h00020000, 2, 4, 1'b1};
    tbl[3] = '{13, 3, 32'h80000000, 0, 3, 1'b0, 32'h80000000, 0, 3, 1'b0};
    tbl[4] = '{16, 2, 32'h00020000, 0, 2, 1'b0, 32'h00020000, 0, 2, 1'b0};
    tbl[5] = '{18, 3, 32'h80000000, 2, 3, 1'b0, 32'h80000000, 2, 3, 1'b0};
    tbl[6] = '{21, 3, 32'h7FFFFFFF, 1, 3, 1'b0, 32'h7FFFFFFF, 1, 3, 1'b0};
    tbl[7] = '{24, 2, 32'h80000000, 0, 2, 1'b0, 32'h80000000, 0, 2, 1'b0};
    tbl[8] = '{26, 1, 32'h80050000, 0, 1, 1'b0, 32'h80050000, 0, 1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready),  64'd1);
    chk("rst_max",   64'(bus.out_max),   64'd0);
    chk("rst_index", 64'(bus.out_index), 64'd0);
    chk("rst_count", 64'(bus.out_count), 64'd0);
    chk("rst_ovf",   64'(bus.out_ovf),   64'd0);

    for (int v = 0; v < NV; v++) begin
      for (int b = 0; b < tbl[v].len; b++)
        drive_beat(beats[tbl[v].start + b], b == tbl[v].len - 1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk($sformatf("v%0d_valid", v),  64'(bus.out_valid),  64'd1);
      chk($sformatf("v%0d_ready", v),  64'(bus.in_ready),   64'd0);
      chk($sformatf("v%0d_max", v),    64'(bus.out_max),    64'(tbl[v].mx));
      chk($sformatf("v%0d_index", v),  64'(bus.out_index),  64'(tbl[v].ix));
      chk($sformatf("v%0d_count", v),  64'(bus.out_count),  64'(tbl[v].cn));
      chk($sformatf("v%0d_ovf", v),    64'(bus.out_ovf),    64'(tbl[v].ov));
      chk($sformatf("v%0d_valid4", v), 64'(bus4.out_valid), 64'd1);
      chk($sformatf("v%0d_max4", v),   64'(bus4.out_max),   64'(tbl[v].mx4));
      chk($sformatf("v%0d_index4", v), 64'(bus4.out_index), 64'(tbl[v].ix4));
      chk($sformatf("v%0d_count4", v), 64'(bus4.out_count), 64'(tbl[v].cn4));
      chk($sformatf("v%0d_ovf4", v),   64'(bus4.out_ovf),   64'(tbl[v].ov4));
      handshake();
    end

    // Backpressure: result held, and a waiting beat is not taken during HOLD.
    drive_beat(32'h80050000, 1'b1);
    bus.in_data = 32'h00070000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_ready", 64'(bus.in_ready),  64'd0);
      chk("bp_max",   64'(bus.out_max),   64'h80050000);
      chk("bp_count", 64'(bus.out_count), 64'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_hs_ready", 64'(bus.in_ready),  64'd1);
    chk("bp_hs_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_next_max",   64'(bus.out_max),   64'h00070000);
    chk("bp_next_index", 64'(bus.out_index), 64'd0);
    chk("bp_next_count", 64'(bus.out_count), 64'd1);
    handshake();

    // Asynchronous reset mid-frame.
    drive_beat(32'h00500000, 1'b0);
    drive_beat(32'h00600000, 1'b0);
    bus.in_valid = 1'b0;
    chk("mid_count_pre", 64'(bus.out_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_count", 64'(bus.out_count), 64'd0);
    chk("mid_rst_max",   64'(bus.out_max),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset during HOLD.
    drive_beat(32'h00400000, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("hold_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("hold_rst_ready", 64'(bus.in_ready),  64'd1);
    chk("hold_rst_max",   64'(bus.out_max),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive_beat(32'h00010000, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("post_valid", 64'(bus.out_valid), 64'd1);
    chk("post_max",   64'(bus.out_max),   64'h00010000);
    chk("post_index", 64'(bus.out_index), 64'd0);
    chk("post_count", 64'(bus.out_count), 64'd1);
    chk("post_ovf",   64'(bus.out_ovf),   64'd0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
